// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad, debounces whole scan frames
// and emits exactly one PRESS/ENTER/CLEAR strobe per physical keystroke.
module keypad_scan #(
  parameter int SCAN_DIV = 250,
  parameter int DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] CODE,
  output logic       PRESS,
  output logic       ENTER,
  output logic       CLEAR
);

  localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_ENTER, K_CLEAR, K_NONE} kind_t;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] first_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Key index is row*4 + col.
  function automatic kind_t key_kind(input logic [3:0] idx);
    kind_t k;
    case (idx)
      4'd3, 4'd7, 4'd11, 4'd15: k = K_NONE;
      4'd12:                    k = K_CLEAR;
      4'd14:                    k = K_ENTER;
      default:                  k = K_DIGIT;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] idx);
    logic [3:0] d;
    case (idx)
      4'd0:    d = 4'd1;
      4'd1:    d = 4'd2;
      4'd2:    d = 4'd3;
      4'd4:    d = 4'd4;
      4'd5:    d = 4'd5;
      4'd6:    d = 4'd6;
      4'd8:    d = 4'd7;
      4'd9:    d = 4'd8;
      4'd10:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q;
  logic [15:0]   mask_q, mask_d, hits;
  logic          sample, frame_end;

  state_t        state_q;
  logic [3:0]    cand_q, cnt_q, cnt_inc;
  logic [3:0]    code_q;
  logic          press_q, enter_q, clear_q;

  logic [4:0]    nkeys;
  logic          single, empty;
  logic [3:0]    key;
  kind_t         kind;
  logic          accept;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= ROW;
      row_s2_q <= row_s1_q;
    end
  end

  assign sample    = (div_q == DIV_LAST);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign div_d     = sample ? '0 : div_q + 1'b1;
  assign col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

  // Crossings seen in the current column; col0 starts a fresh frame map.
  always_comb begin
    hits = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        hits[r*4 + c] = (col_idx_q == 2'(c)) && !row_s2_q[r];
    mask_d = ((col_idx_q == 2'd0) ? 16'h0000 : mask_q) | hits;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      mask_q    <= '0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      col_q     <= ~(4'b0001 << col_idx_d);
      if (sample) mask_q <= mask_d;
    end
  end

  assign nkeys   = popcnt16(mask_d);
  assign single  = (nkeys == 5'd1);
  assign empty   = (nkeys == 5'd0);
  assign key     = first_idx(mask_d);
  assign kind    = key_kind(key);
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    accept = 1'b0;
    if (frame_end && single) begin
      case (state_q)
        S_IDLE:  accept = (DEB_N == 4'd1);
        S_DEB:   accept = (key == cand_q) && (cnt_inc >= DEB_N);
        default: accept = 1'b0;
      endcase
    end
  end

  // Press/release tracker, advanced once per frame at the col3 sample
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      press_q <= 1'b0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      press_q <= accept && (kind == K_DIGIT);
      enter_q <= accept && (kind == K_ENTER);
      clear_q <= accept && (kind == K_CLEAR);
      if (accept && (kind == K_DIGIT)) code_q <= key_digit(key);
      if (frame_end) begin
        case (state_q)
          S_IDLE: begin
            if (single) begin
              cand_q  <= key;
              cnt_q   <= 4'd1;
              state_q <= (DEB_N == 4'd1) ? S_HELD : S_DEB;
            end
          end
          S_DEB: begin
            if (single && (key == cand_q)) begin
              if (cnt_inc >= DEB_N) begin
                cnt_q   <= '0;
                state_q <= S_HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else if (single) begin
              cand_q <= key;
              cnt_q  <= 4'd1;
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
          S_HELD: begin
            if (empty) begin
              cnt_q   <= (DEB_N == 4'd1) ? 4'd0 : 4'd1;
              state_q <= (DEB_N == 4'd1) ? S_IDLE : S_REL;
            end
          end
          S_REL: begin
            if (empty) begin
              if (cnt_inc >= DEB_N) begin
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_HELD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign COL   = col_q;
  assign CODE  = code_q;
  assign PRESS = press_q;
  assign ENTER = enter_q;
  assign CLEAR = clear_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad and produces the key-event stream consumed by the password lock: a BCD digit on CODE with a one-cycle PRESS strobe, plus one-cycle ENTER (`#`) and CLEAR (`*`) strobes. It sits between the board keypad pins and the lock datapath/control. It performs column scanning, input synchronisation, frame-based debounce and press/release tracking, so each physical keystroke yields exactly one event.

## Interface
Parameters:
- SCAN_DIV, default 250: clock cycles each column is driven. Must be 3 or more.
- DEBOUNCE, default 4: consecutive identical scan frames needed to accept a press or a release. Range 1..15.

Ports:
- CLK  in  1  single system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset, 1 = run).
- ROW  in  4  keypad rows, active-low with external pull-ups, asynchronous to CLK.
- COL  out  4  column drive, active-low, one-hot-low; registered.
- CODE  out  4  BCD value of the last accepted digit key (0–9); held between presses.
- PRESS  out  1  one-cycle strobe; a digit was accepted and CODE is valid in this cycle.
- ENTER  out  1  one-cycle strobe; `#` was accepted.
- CLEAR  out  1  one-cycle strobe; `*` was accepted.

## Operation
- Keymap by row/col, index 0..3:
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = * 0 # D
- A–D are recognised and debounced like any key but produce no strobe and leave CODE unchanged.
- ROW passes through a 2-flop synchroniser before any use.
- Scan:
  - COL cycles col0→col1→col2→col3→col0, each held SCAN_DIV cycles. Active column = 0, others = 1.
  - The synchronised ROW is sampled in the last cycle of each column slot.
  - A frame is 4×SCAN_DIV cycles, starting at col0.
- Frame classification at the col3 sample: EMPTY (no row low in any column), SINGLE(k) (exactly one row/col crossing), or MULTI (two or more).
- FSM states and transitions, evaluated once per frame:
  - IDLE: SINGLE(k) → latch cand = k, cnt = 1, go to DEB; if DEBOUNCE = 1, accept immediately and go to HELD. EMPTY or MULTI → stay.
  - DEB: SINGLE(cand) → cnt+1; at cnt = DEBOUNCE, accept and go to HELD. SINGLE(other) → cand = new key, cnt = 1. EMPTY or MULTI → IDLE.
  - HELD: EMPTY → rel = 1, go to REL. SINGLE or MULTI → stay. Rollover to another key never produces an event.
  - REL: EMPTY → rel+1; at rel = DEBOUNCE go to IDLE. SINGLE or MULTI → HELD.
- Accept action, all in one cycle:
  - digit: CODE ← value and PRESS = 1.
  - `#`: ENTER = 1. `*`: CLEAR = 1.
- At most one strobe is high in any cycle.
- Counters saturate and cannot wrap. The scan counter wraps freely.

## Timing
- Reset values: COL = 4'b1110 (col0 active), CODE = 0, PRESS = ENTER = CLEAR = 0, FSM = IDLE, synchronisers = 4'b1111, all counters = 0.
- Reset is asynchronous and can occur mid-frame or mid-debounce. Any in-progress event is discarded. A key held through reset release must be re-debounced from IDLE, so one event occurs after the full debounce.
- Strobes are registered and assert the cycle after the col3 sample of the accepting frame.
  - Minimum latency from a clean, stable press at frame start: DEBOUNCE×4×SCAN_DIV + 1 cycles, plus 2 cycles of synchroniser delay.
- CODE changes only in a PRESS cycle and is stable from that cycle until the next PRESS.
- Minimum spacing between two events is 2×DEBOUNCE frames (press debounce + release debounce).
- Glitches shorter than one column slot affect at most one frame, so they are rejected whenever DEBOUNCE ≥ 2.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE = 3, giving a 16-cycle frame.
- Reset, then no key → COL rotates 1110, 1101, 1011, 0111 every 4 cycles. All strobes stay 0 and CODE = 0 for 200 cycles.
- Hold "7" (r2 c0) for 10 frames, then release → exactly one PRESS with CODE = 7, 49–51 cycles after the press. CODE stays 7 after release.
- Press "#", release; press "*", release → one ENTER, then one CLEAR. PRESS never asserts and CODE is unchanged.
- Press "5" with 1-frame bounce (on, off, on …) → no event until 3 clean frames. Then exactly one PRESS with CODE = 5. A 1-frame release gap while still held → no second event.
- Hold "1" and "2" together from IDLE → no event. Hold "3" (accepted, CODE = 3) then add "9" and release "3" → no new event until full release and a new press.
- Assert RESET mid-DEB on "4", keep "4" held, deassert → CODE = 0 during reset. One PRESS with CODE = 4 about 3 frames after reset release.
